seq_mult: RTL and testbench

Parametrised sequential shift-and-add multiplier; the multi-cycle successor of the team's 4-bit combinational array multiplier. It multiplies two WIDTH-bit operands, either unsigned or two's-complement signed, selected per operation. It uses one adder over WIDTH cycles and a valid/ready handshake on both sides. It sits in the ALU datapath beside the adder and logic units, where a full array multiplier is too large for WIDTH ≥ 8.

---
 rtl/seq_mult_pkg.sv | 15 +
 rtl/seq_mult_abs.sv | 13 +
 rtl/seq_mult.sv | 92 +++++++++
 tb/tb_seq_mult.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared ALU definitions for the sequential multiplier: FSM states and counter sizing.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must hold 0..w inclusive (w add/shift steps plus the final negate step).
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_mult_abs.sv
// Conditional two's-complement magnitude: returns |x| when en and x is negative, else x raw.
module twos_abs #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] x,
  input  logic         en,
  output logic [W-1:0] mag
);

  // The most-negative value maps onto itself, which reads correctly as unsigned 2^(W-1).
  assign mag = (en && x[W-1]) ? (~x + W'(1)) : x;

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-and-add multiplier, unsigned or signed per operation, valid/ready on both sides.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [PW:0]      sr;
  logic             neg;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   addend_c;
  logic [WIDTH:0]   sum_c;

  twos_abs #(.W(WIDTH)) u_abs_a (.x(a), .en(signed_mode), .mag(a_mag));
  twos_abs #(.W(WIDTH)) u_abs_b (.x(b), .en(signed_mode), .mag(b_mag));

  // Single adder: multiplicand into the upper WIDTH+1 bits when the multiplier LSB is set.
  always_comb begin
    addend_c = '0;
    if (sr[0]) addend_c = {1'b0, mcand};
    sum_c = sr[PW:WIDTH] + addend_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mcand     <= '0;
      sr        <= '0;
      neg       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      product   <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            mcand    <= a_mag;
            sr       <= {{(WIDTH + 1){1'b0}}, b_mag};
            neg      <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            cnt      <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          // Steps 0..WIDTH-1 add/shift; the extra step applies the sign and publishes.
          if (cnt == CW'(WIDTH)) begin
            product   <= neg ? (~sr[PW-1:0] + PW'(1)) : sr[PW-1:0];
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            sr  <= {1'b0, sum_c, sr[WIDTH-1:1]};
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult at WIDTH 2/4/8/16 against an integer-arithmetic reference.
module tb_seq_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [3:0]  signed_mode;
  logic [15:0] a_bus [4];
  logic [15:0] b_bus [4];
  logic [31:0] prod  [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned W = 2 << g;
    logic [2*W-1:0] p;
    seq_mult #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid[g]),
      .in_ready    (in_ready[g]),
      .a           (a_bus[g][W-1:0]),
      .b           (b_bus[g][W-1:0]),
      .signed_mode (signed_mode[g]),
      .out_valid   (out_valid[g]),
      .out_ready   (out_ready[g]),
      .product     (p)
    );
    assign prod[g] = 32'(p);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: interpret operands as integers of width 2<<k and multiply.
  function automatic logic [31:0] model(input int k, input logic sm,
                                        input logic [15:0] av, input logic [15:0] bv);
    int    w    = 2 << k;
    longint mask = (longint'(1) << w) - 1;
    longint x    = longint'(av) & mask;
    longint y    = longint'(bv) & mask;
    if (sm && x >= (longint'(1) << (w - 1))) x -= (longint'(1) << w);
    if (sm && y >= (longint'(1) << (w - 1))) y -= (longint'(1) << w);
    return 32'((x * y) & ((longint'(1) << (2 * w)) - 1));
  endfunction

  // One full transaction on instance k; entered and left at a negedge.
  task automatic do_op(input int k, input logic sm, input logic [15:0] av,
                       input logic [15:0] bv, input int hold, input string tag);
    int          w = 2 << k;
    int          c = 0;
    logic [31:0] exp;
    for (int t = 0; t < 50 && !in_ready[k]; t++) @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready[k]), 32'd1);
    a_bus[k] = av; b_bus[k] = bv; signed_mode[k] = sm; in_valid[k] = 1'b1;
    exp = model(k, sm, a_bus[k], b_bus[k]);
    @(posedge clk);
    @(negedge clk);
    in_valid[k] = 1'b0;
    a_bus[k] = 16'($urandom); b_bus[k] = 16'($urandom); signed_mode[k] = ~sm;
    while (!out_valid[k] && c < 100) begin
      @(posedge clk); c++;
      @(negedge clk);
    end
    check({tag, "_latency"}, 32'(c), 32'(w + 1));
    check({tag, "_product"}, prod[k], exp);
    check({tag, "_busy_not_ready"}, 32'(in_ready[k]), 32'd0);
    for (int h = 0; h < hold; h++) begin
      in_valid[k] = 1'b1; a_bus[k] = 16'($urandom); b_bus[k] = 16'($urandom);
      @(posedge clk);
      @(negedge clk);
      check({tag, "_hold_product"}, prod[k], exp);
      check({tag, "_hold_valid"}, 32'(out_valid[k]), 32'd1);
      check({tag, "_hold_ready"}, 32'(in_ready[k]), 32'd0);
    end
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[k] = 1'b0;
    check({tag, "_drop_valid"}, 32'(out_valid[k]), 32'd0);
    check({tag, "_idle_ready"}, 32'(in_ready[k]), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] corner [4];
    corner[0] = 16'h0000; corner[1] = 16'hFFFF; corner[2] = 16'h8000; corner[3] = 16'h0001;
    rst = 1'b1; in_valid = '0; out_ready = '0; signed_mode = '0;
    for (int k = 0; k < 4; k++) begin a_bus[k] = '0; b_bus[k] = '0; end
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    for (int k = 0; k < 4; k++) check("rst_product", prod[k], 32'h0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'hF);

    do_op(1, 1'b0, 16'hF, 16'hF, 0, "u4_15x15");
    do_op(1, 1'b1, 16'h8, 16'h8, 0, "s4_m8xm8");
    do_op(1, 1'b1, 16'h7, 16'h8, 0, "s4_7xm8");
    do_op(2, 1'b1, 16'hFF, 16'h01, 0, "s8_m1x1");
    do_op(2, 1'b0, 16'hFF, 16'h01, 0, "u8_255x1");
    do_op(2, 1'b0, 16'h00, 16'hAB, 0, "u8_0xab");
    do_op(2, 1'b1, 16'h80, 16'h80, 0, "s8_min_sq");
    do_op(2, 1'b0, 16'd200, 16'd3, 20, "u8_backpressure");
    do_op(2, 1'b0, 16'd9, 16'd7, 0, "u8_after_bp");

    // Reset during the third BUSY cycle discards the operation.
    a_bus[2] = 16'd100; b_bus[2] = 16'd100; signed_mode[2] = 1'b0; in_valid[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[2] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid[2]), 32'd0);
    check("midrst_product", prod[2], 32'h0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready[2]), 32'd1);
    check("midrst_no_valid", 32'(out_valid[2]), 32'd0);
    do_op(2, 1'b0, 16'd3, 16'd5, 0, "u8_3x5_after_rst");

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 25; i++) begin
        logic [15:0] av = 16'($urandom);
        logic [15:0] bv = 16'($urandom);
        if (i % 5 == 0) begin
          av = corner[$urandom_range(0, 3)] >> (16 - (2 << k));
          if (i % 10 == 0) av = 16'h1 << ((2 << k) - 1);
        end
        do_op(k, 1'($urandom_range(0, 1)), av, bv, int'($urandom_range(0, 2)), "rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
